// File: rtl/column_audio_pkg.sv
// Shared widths, tap FSM state type and the 1.17 -> saturated s16 conversion
// for the column audio tap.
package column_audio_pkg;

    localparam int ROW_W = 5;
    localparam int U_W   = 18;
    localparam int AUD_W = 16;

    typedef enum logic [1:0] {
        WAIT_LEAVE,
        ARMED,
        SETTLING,
        CAPTURE
    } tap_state_t;

    // Truncate 1.17 to 1.15, then left shift; clamp when the bits shifted out
    // disagree with the resulting sign.
    function automatic logic [AUD_W-1:0] sat_shift16(input logic [U_W-1:0] u,
                                                     input logic [2:0]     shift);
        logic [AUD_W+7:0] wide;
        wide = {{8{u[U_W-1]}}, u[U_W-1:2]} << shift;
        if ((&wide[AUD_W+7:AUD_W-1]) || !(|wide[AUD_W+7:AUD_W-1]))
            return wide[AUD_W-1:0];
        else if (u[U_W-1])
            return 16'h8000;
        else
            return 16'h7FFF;
    endfunction

endpackage

// File: rtl/column_audio_tap_if.sv
// Audio sample stream from the column tap to the audio-bus master.
// Handshake: a beat transfers on a rising clk edge where aud_valid && aud_ready;
// aud_data is held stable while aud_valid && !aud_ready, and aud_valid never
// depends combinationally on aud_ready.
interface column_audio_tap_if;
    import column_audio_pkg::*;

    logic [AUD_W-1:0] aud_data;
    logic             aud_valid;
    logic             aud_ready;

    modport master (output aud_data, output aud_valid, input aud_ready);
    modport slave  (input aud_data, input aud_valid, output aud_ready);

endinterface

// File: rtl/audio_tap_fifo.sv
// Synchronous FIFO with a registered head word, separate occupancy count and a
// one-cycle drop flag for pushes refused while full.
module audio_tap_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             drop
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [LVL_W-1:0] level_nx;
    logic             full;
    logic             pop_ok;
    logic             push_ok;

    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push && (!full || pop_ok);
    assign drop      = push && !push_ok;
    assign rd_ptr_nx = pop_ok ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        level_nx = level;
        if (push_ok && !pop_ok)
            level_nx = level + 1'b1;
        else if (!push_ok && pop_ok)
            level_nx = level - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nx;
            level  <= level_nx;
            // The next head is the word being written when it lands in the read slot.
            if (level_nx == '0)
                dout <= '0;
            else if (push_ok && (wr_ptr == rd_ptr_nx))
                dout <= din;
            else
                dout <= mem[rd_ptr_nx];
        end
    end

endmodule

// File: rtl/column_audio_tap.sv
// Samples u_np1 at the tap row once per time step, converts it to saturated s16
// audio and buffers it. Optional peak meter: define AUDIO_TAP_PEAK_EN.
module column_audio_tap
    import column_audio_pkg::*;
#(
    parameter  int NUM_ROW    = 33,
    parameter  int TAP_ROW    = 16,
    parameter  int SETTLE     = 2,
    parameter  int DECIM      = 1,
    parameter  int GAIN_SHIFT = 0,
    parameter  int FIFO_DEPTH = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [ROW_W-1:0]     row_in,
    input  logic [U_W-1:0]       u_np1_in,
    column_audio_tap_if.master   aud,
    output logic                 sim_hold,
    output logic                 overflow,
    output logic [15:0]          drop_cnt,
    output logic [LVL_W-1:0]     fifo_level,
    output tap_state_t           tap_state
`ifdef AUDIO_TAP_PEAK_EN
    ,
    output logic [AUD_W-1:0]     peak,
    input  logic                 peak_clr
`endif
);

    if (TAP_ROW >= NUM_ROW || SETTLE < 1 || SETTLE > 7 || DECIM < 1 || DECIM > 255 ||
        GAIN_SHIFT < 0 || GAIN_SHIFT > 7 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("column_audio_tap: illegal parameter set");
    end

    localparam logic [ROW_W-1:0] TAP = ROW_W'(TAP_ROW);

    logic [2:0]       settle_cnt;
    logic [7:0]       decim_cnt;
    logic             decim_hit;
    logic             push;
    logic             drop;
    logic             fifo_empty;
    logic [AUD_W-1:0] sample;

    assign decim_hit = (decim_cnt == 8'(DECIM - 1));
    assign push      = en && (tap_state == CAPTURE) && decim_hit;
    assign sample    = sat_shift16(u_np1_in, 3'(GAIN_SHIFT));

    always_ff @(posedge clk) begin
        if (rst) begin
            tap_state  <= WAIT_LEAVE;
            settle_cnt <= '0;
            decim_cnt  <= '0;
        end else if (!en) begin
            tap_state <= WAIT_LEAVE;
        end else begin
            case (tap_state)
                // Only arm once the column has moved off the tap row.
                WAIT_LEAVE: if (row_in != TAP) tap_state <= ARMED;
                ARMED: begin
                    if (row_in == TAP) begin
                        tap_state  <= SETTLING;
                        settle_cnt <= 3'(SETTLE - 1);
                    end
                end
                SETTLING: begin
                    if (row_in != TAP)
                        tap_state <= ARMED;
                    else if (settle_cnt == '0)
                        tap_state <= CAPTURE;
                    else
                        settle_cnt <= settle_cnt - 1'b1;
                end
                CAPTURE: begin
                    tap_state <= WAIT_LEAVE;
                    decim_cnt <= decim_hit ? 8'd0 : decim_cnt + 8'd1;
                end
                default: tap_state <= WAIT_LEAVE;
            endcase
        end
    end

    audio_tap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AUD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sample),
        .pop   (aud.aud_ready),
        .dout  (aud.aud_data),
        .level (fifo_level),
        .empty (fifo_empty),
        .drop  (drop)
    );

    assign aud.aud_valid = !fifo_empty;

    // sim_hold lags fifo_level by a cycle, so it trips one entry early.
    always_ff @(posedge clk) begin
        if (rst) begin
            sim_hold <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            sim_hold <= (fifo_level >= LVL_W'(FIFO_DEPTH - 1));
            if (drop)
                overflow <= 1'b1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

`ifdef AUDIO_TAP_PEAK_EN
    logic [AUD_W-1:0] mag;

    always_comb begin
        mag = sample;
        if (sample == 16'h8000)
            mag = 16'h7FFF;
        else if (sample[AUD_W-1])
            mag = -sample;
    end

    always_ff @(posedge clk) begin
        if (rst)
            peak <= '0;
        else if (push && !drop)
            peak <= (peak_clr || mag > peak) ? mag : peak;
        else if (peak_clr)
            peak <= '0;
    end
`endif

endmodule

// File: tb/tb_column_audio_tap.sv
// Directed bench for column_audio_tap: three instances (default, GAIN_SHIFT=3,
// DECIM=4) share the simulator stimulus; per-instance scoreboards check output.
module tb_column_audio_tap;
    import column_audio_pkg::*;

    localparam int NUM_ROW = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [4:0]  row_in;
    logic [17:0] u_np1_in;

    always #5 clk = ~clk;

    column_audio_tap_if bus_a ();
    column_audio_tap_if bus_g ();
    column_audio_tap_if bus_d ();

    logic        sim_hold_a, ovf_a, sim_hold_g, ovf_g, sim_hold_d, ovf_d;
    logic [15:0] drop_a, drop_g, drop_d;
    logic [3:0]  lvl_a, lvl_g, lvl_d;
    tap_state_t  st_a, st_g, st_d;

    column_audio_tap dut_a (
        .clk(clk), .rst(rst), .en(en), .row_in(row_in), .u_np1_in(u_np1_in), .aud(bus_a),
        .sim_hold(sim_hold_a), .overflow(ovf_a), .drop_cnt(drop_a), .fifo_level(lvl_a),
        .tap_state(st_a)
    );

    column_audio_tap #(.GAIN_SHIFT(3)) dut_g (
        .clk(clk), .rst(rst), .en(en), .row_in(row_in), .u_np1_in(u_np1_in), .aud(bus_g),
        .sim_hold(sim_hold_g), .overflow(ovf_g), .drop_cnt(drop_g), .fifo_level(lvl_g),
        .tap_state(st_g)
    );

    column_audio_tap #(.DECIM(4)) dut_d (
        .clk(clk), .rst(rst), .en(en), .row_in(row_in), .u_np1_in(u_np1_in), .aud(bus_d),
        .sim_hold(sim_hold_d), .overflow(ovf_d), .drop_cnt(drop_d), .fifo_level(lvl_d),
        .tap_state(st_d)
    );

    logic [15:0] exp_a[$];
    logic [15:0] exp_g[$];
    logic [15:0] exp_d[$];
    int compared   = 0;
    int mismatched = 0;
    int pops_a = 0, pops_g = 0, pops_d = 0;
    int d_cnt  = 0;
    bit pulse_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitors: every accepted beat is matched against the head of its queue.
    always @(negedge clk) begin : mon_a
        logic [15:0] e;
        if (bus_a.aud_valid && bus_a.aud_ready) begin
            pops_a++;
            if (exp_a.size() == 0) check("aud_a_unexpected", {16'h0, bus_a.aud_data}, 32'hFFFF_FFFF);
            else begin e = exp_a.pop_front(); check("aud_a", {16'h0, bus_a.aud_data}, {16'h0, e}); end
        end
    end

    always @(negedge clk) begin : mon_g
        logic [15:0] e;
        if (bus_g.aud_valid && bus_g.aud_ready) begin
            pops_g++;
            if (exp_g.size() == 0) check("aud_g_unexpected", {16'h0, bus_g.aud_data}, 32'hFFFF_FFFF);
            else begin e = exp_g.pop_front(); check("aud_g", {16'h0, bus_g.aud_data}, {16'h0, e}); end
        end
    end

    always @(negedge clk) begin : mon_d
        logic [15:0] e;
        if (bus_d.aud_valid && bus_d.aud_ready) begin
            pops_d++;
            if (exp_d.size() == 0) check("aud_d_unexpected", {16'h0, bus_d.aud_data}, 32'hFFFF_FFFF);
            else begin e = exp_d.pop_front(); check("aud_d", {16'h0, bus_d.aud_data}, {16'h0, e}); end
        end
    end

    // One column traversal, 3 cycles per row, u_np1 held for the whole sweep.
    task automatic traverse(input logic [17:0] v, input bit a_exp, input logic [15:0] a_val,
                            input logic [15:0] g_val, input bit pulse);
        if (en) begin
            if (a_exp) exp_a.push_back(a_val);
            exp_g.push_back(g_val);
            if (d_cnt == 3) begin exp_d.push_back(v[17:2]); d_cnt = 0; end
            else d_cnt++;
        end
        u_np1_in = v;
        for (int r = 0; r < NUM_ROW; r++) begin
            row_in = 5'(r);
            repeat (3) begin
                @(posedge clk); #1;
                if (pulse) begin
                    bus_a.aud_ready = (st_a == CAPTURE);
                    if (st_a == CAPTURE) pulse_seen = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while ((exp_a.size() != 0 || exp_g.size() != 0 || exp_d.size() != 0) && c < bound) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (2) begin @(posedge clk); #1; end
        check("drain_in_time", 32'(c < bound), 32'd1);
    endtask

    initial begin
        int base_d;
        int c;
        rst = 1'b1; en = 1'b1; row_in = '0; u_np1_in = '0;
        bus_a.aud_ready = 1'b0; bus_g.aud_ready = 1'b1; bus_d.aud_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", st_a, WAIT_LEAVE);
        check("rst_level", lvl_a, 0);
        check("rst_valid", bus_a.aud_valid, 0);
        check("rst_data", bus_a.aud_data, 0);
        check("rst_sim_hold", sim_hold_a, 0);
        check("rst_overflow", ovf_a, 0);
        check("rst_drop_cnt", drop_a, 0);
        rst = 1'b0;

        // Single sweep, then saturation corners.
        bus_a.aud_ready = 1'b1;
        traverse(18'h04000, 1, 16'h1000, 16'h7FFF, 0);
        check("sweep_one_push", pops_a, 1);
        traverse(18'h1FFFF, 1, 16'h7FFF, 16'h7FFF, 0);
        traverse(18'h20000, 1, 16'h8000, 16'h8000, 0);
        traverse(18'h3FFF0, 1, 16'hFFFC, 16'hFFE0, 0);
        check("decim_first", pops_d, 1);

        // Decimation by 4 over eight traversals.
        base_d = pops_d;
        for (int i = 0; i < 8; i++)
            traverse(18'(18'h00100 * (i + 1)), 1, 16'(16'h0040 * (i + 1)), 16'(16'h0200 * (i + 1)), 0);
        check("decim_two_in_eight", pops_d - base_d, 2);

        // Fill with no consumer: 8 kept, 2 dropped.
        bus_a.aud_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            traverse(18'(18'h00400 * (k + 1)), k < 8, 16'(16'h0100 * (k + 1)), 16'(16'h0800 * (k + 1)), 0);
            if (k == 5) check("sim_hold_lvl6", sim_hold_a, 0);
            if (k == 6) check("sim_hold_lvl7", sim_hold_a, 1);
        end
        check("full_level", lvl_a, 8);
        check("full_drop_cnt", drop_a, 2);
        check("full_overflow", ovf_a, 1);
        check("full_sim_hold", sim_hold_a, 1);
        check("full_head", bus_a.aud_data, 16'h0100);

        // Pop in the capture cycle of a full FIFO: accepted, nothing dropped.
        pulse_seen = 1'b0;
        traverse(18'h0C000, 1, 16'h3000, 16'h7FFF, 1);
        check("pulse_seen", pulse_seen, 1);
        check("pulse_level", lvl_a, 8);
        check("pulse_drop_cnt", drop_a, 2);
        check("pulse_head", bus_a.aud_data, 16'h0200);

        bus_a.aud_ready = 1'b1;
        wait_drain(50);
        check("drain_level", lvl_a, 0);
        check("drain_valid", bus_a.aud_valid, 0);
        check("drain_overflow_sticky", ovf_a, 1);

        // Reset while SETTLING with 3 entries queued.
        bus_a.aud_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            traverse(18'(18'h00400 * (k + 1)), 0, 16'h0, 16'(16'h0800 * (k + 1)), 0);
        check("pre_rst_level", lvl_a, 3);
        u_np1_in = 18'h04000;
        for (int r = 0; r < 16; r++) begin
            row_in = 5'(r);
            repeat (3) begin @(posedge clk); #1; end
        end
        row_in = 5'd16;
        c = 0;
        while (st_a != SETTLING && c < 10) begin @(posedge clk); #1; c++; end
        check("settling_reached", st_a, SETTLING);
        rst = 1'b1;
        d_cnt = 0;
        @(posedge clk); #1;
        check("mid_rst_level", lvl_a, 0);
        check("mid_rst_valid", bus_a.aud_valid, 0);
        check("mid_rst_state", st_a, WAIT_LEAVE);
        check("mid_rst_overflow", ovf_a, 0);
        rst = 1'b0;
        // Parked on the tap row after reset: this pass must not capture.
        for (int r = 16; r < NUM_ROW; r++) begin
            row_in = 5'(r);
            repeat (3) begin @(posedge clk); #1; end
        end
        check("parked_no_capture", lvl_a, 0);

        en = 1'b0;
        traverse(18'h04000, 0, 16'h0, 16'h0, 0);
        check("en_off_level", lvl_a, 0);
        check("en_off_state", st_a, WAIT_LEAVE);
        en = 1'b1;

        bus_a.aud_ready = 1'b1;
        traverse(18'h04000, 1, 16'h1000, 16'h7FFF, 0);
        wait_drain(50);
        check("end_queue_a", exp_a.size(), 0);
        check("end_queue_g", exp_g.size(), 0);
        check("end_queue_d", exp_d.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
